// File: rtl/mem_ctrl_pkg.sv
// Shared defaults, BIST state encoding and the address-derived test pattern
// used by the BRAM self-test master.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 17;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    FIN     = 3'd4
  } bist_state_e;

  // Folding all address bytes into the pattern makes aliased address lines
  // show up as data mismatches.
  function automatic logic [7:0] pat(input logic [16:0] a, input logic [7:0] seed);
    return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ seed;
  endfunction

endpackage

// File: rtl/mem_bist_master.sv
// BRAM self-test master: writes pat(a) over [base, last], reads it back one
// request at a time, and reports mismatches/timeouts.
module mem_bist_master
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [DATA_W-1:0] seed,
  output logic              en,
  output logic              wr,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] wdata_out,
  input  logic [DATA_W-1:0] rdata_in,
  input  logic              rdata_rdy,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int unsigned       TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [15:0]       ERR_MAX  = '1;

  bist_state_e       state;
  logic [ADDR_W-1:0] a;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] last_r;
  logic [DATA_W-1:0] seed_r;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [15:0]       err_r;
  logic [ADDR_W-1:0] first_err_r;

  logic [DATA_W-1:0] exp_data;
  logic              at_last;
  logic              rd_hit;
  logic              rd_timeout;
  logic              rd_done;
  logic              err_evt;

  assign exp_data = DATA_W'(pat(17'(a), 8'(seed_r)));

  // Data arriving on the final wait cycle wins over the timeout.
  always_comb begin
    at_last    = (a == last_r);
    rd_hit     = (state == RD_WAIT) && rdata_rdy;
    rd_timeout = (state == RD_WAIT) && !rdata_rdy && (tmo_cnt == TMO_LAST);
    rd_done    = rd_hit || rd_timeout;
    err_evt    = (rd_hit && (rdata_in != exp_data)) || rd_timeout;
  end

  always_comb begin
    en        = 1'b0;
    wr        = 1'b0;
    addr_out  = '0;
    wdata_out = '0;
    case (state)
      WRITE: begin
        en        = 1'b1;
        wr        = 1'b1;
        addr_out  = a;
        wdata_out = exp_data;
      end
      RD_REQ: begin
        en       = 1'b1;
        addr_out = a;
      end
      default: ;
    endcase
  end

  assign busy           = (state == WRITE) || (state == RD_REQ) || (state == RD_WAIT);
  assign done           = (state == FIN);
  assign pass           = (state == FIN) && (err_r == '0);
  assign err_cnt        = err_r;
  assign first_err_addr = first_err_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a           <= '0;
      base_r      <= '0;
      last_r      <= '0;
      seed_r      <= '0;
      tmo_cnt     <= '0;
      err_r       <= '0;
      first_err_r <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            base_r  <= base_addr;
            last_r  <= last_addr;
            seed_r  <= seed;
            a       <= base_addr;
            tmo_cnt <= '0;
            // An inverted range is reported as a single error without touching memory.
            if (base_addr > last_addr) begin
              err_r       <= 16'd1;
              first_err_r <= base_addr;
              state       <= FIN;
            end else begin
              err_r       <= '0;
              first_err_r <= '0;
              state       <= WRITE;
            end
          end
        end
        WRITE: begin
          if (at_last) begin
            a     <= base_r;
            state <= RD_REQ;
          end else begin
            a <= a + 1'b1;
          end
        end
        RD_REQ: begin
          tmo_cnt <= '0;
          state   <= RD_WAIT;
        end
        RD_WAIT: begin
          if (rd_done) begin
            if (at_last) begin
              state <= FIN;
            end else begin
              a     <= a + 1'b1;
              state <= RD_REQ;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
          if (err_evt) begin
            if (err_r != ERR_MAX) err_r <= err_r + 1'b1;
            if (err_r == '0) first_err_r <= a;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_master.sv
// Scoreboard bench for mem_bist_master: expected requests/results are queued
// per test and checked by a monitor as the DUT presents them.
module tb_mem_bist_master;

  localparam int AW = 17;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] seed = '0;
  logic          en, wr, busy, done, pass;
  logic [AW-1:0] addr_out, first_err_addr;
  logic [DW-1:0] wdata_out;
  logic [DW-1:0] rdata_in = '0;
  logic          rdata_rdy = 1'b0;
  logic [15:0]   err_cnt;

  mem_bist_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .last_addr(last_addr), .seed(seed), .en(en), .wr(wr), .addr_out(addr_out),
    .wdata_out(wdata_out), .rdata_in(rdata_in), .rdata_rdy(rdata_rdy),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; int addr; logic [7:0] wdata; int gap; } req_t;
  typedef struct { int err; logic pass; int first; logic chk_first; } res_t;

  req_t req_q[$];
  res_t res_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   sb_on = 1'b1;
  bit   noise = 1'b0;
  int   corrupt_addr = -1;
  int   drop_addr = -1;
  int   slow_addr = -1;
  logic [7:0] mem [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_pat(int a, logic [7:0] s);
    return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ s;
  endfunction

  // Reads following a 16-cycle wait on tmo_addr come 17 cycles after the previous request.
  task automatic push_range(int b, int l, logic [7:0] s, int tmo_addr);
    req_t r;
    for (int a = b; a <= l; a++) begin
      r.wr = 1'b1; r.addr = a; r.wdata = ref_pat(a, s); r.gap = (a == b) ? 0 : 1;
      req_q.push_back(r);
    end
    for (int a = b; a <= l; a++) begin
      r.wr = 1'b0; r.addr = a; r.wdata = '0;
      r.gap = (a == b) ? 1 : ((a == tmo_addr + 1) ? 17 : 0);
      req_q.push_back(r);
    end
  endtask

  task automatic push_res(int e, logic p, int f, logic cf);
    res_t r;
    r.err = e; r.pass = p; r.first = f; r.chk_first = cf;
    res_q.push_back(r);
  endtask

  task automatic issue_start(int b, int l, logic [7:0] s);
    @(posedge clk); #1;
    base_addr = b[AW-1:0]; last_addr = l[AW-1:0]; seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(string name, int limit);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_done_timeout: got done=%0b expected 1 within %0d cycles", name, done, limit);
    end
    repeat (3) @(negedge clk);
    chk({name, "_reqs_left"}, req_q.size(), 0);
    chk({name, "_res_left"}, res_q.size(), 0);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_wr"}, wr, 0);
    chk({tag, "_addr"}, addr_out, 0);
    chk({tag, "_wdata"}, wdata_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_first_err"}, first_err_addr, 0);
  endtask

  // Monitor: pops one expected request per en cycle and one result per finished test.
  initial begin : monitor
    int   last_req;
    logic armed;
    req_t r;
    res_t e;
    last_req = -1;
    armed = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        armed = 1'b0;
        last_req = -1;
      end else begin
        if (armed && done) begin
          armed = 1'b0;
          if (res_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done: got done=1 expected no result pending");
          end else begin
            e = res_q.pop_front();
            chk("res_err_cnt", err_cnt, e.err);
            chk("res_pass", pass, e.pass);
            chk("res_busy", busy, 0);
            if (e.chk_first) chk("res_first_err_addr", first_err_addr, e.first);
          end
        end
        if (start && !busy) armed = 1'b1;
        if (en && sb_on) begin
          if (req_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_req: got en wr=%0b addr=%0h expected none", wr, addr_out);
          end else begin
            r = req_q.pop_front();
            chk("req_wr", wr, r.wr);
            chk("req_addr", addr_out, r.addr);
            if (r.wr) chk("req_wdata", wdata_out, r.wdata);
            if (r.gap > 0) chk("req_gap", cyc - last_req, r.gap);
          end
          last_req = cyc;
        end
      end
    end
  end

  // Memory/controller model: one-cycle read latency unless delayed, dropped or corrupted.
  initial begin : mem_model
    bit pend, was_pend;
    int pend_addr, pend_cnt;
    pend = 1'b0;
    pend_addr = 0;
    pend_cnt = 0;
    forever begin
      @(negedge clk);
      was_pend = pend;
      rdata_rdy = 1'b0;
      rdata_in = '0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (pend_cnt == 0) begin
            rdata_rdy = 1'b1;
            rdata_in = mem[pend_addr] ^ ((pend_addr == corrupt_addr) ? 8'h01 : 8'h00);
            pend = 1'b0;
          end else begin
            pend_cnt--;
          end
        end
        if (en) begin
          if (wr) begin
            mem[int'(addr_out)] = wdata_out;
            if (noise) begin rdata_rdy = 1'b1; rdata_in = ~wdata_out; end
          end else begin
            chk("one_outstanding", was_pend, 0);
            if (int'(addr_out) != drop_addr) begin
              pend = 1'b1;
              pend_addr = int'(addr_out);
              pend_cnt = (int'(addr_out) == slow_addr) ? 15 : 0;
            end
            if (noise) begin rdata_rdy = 1'b1; rdata_in = ~mem[int'(addr_out)]; end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Clean memory, stray rdata_rdy pulses outside RD_WAIT.
    noise = 1'b1;
    push_range(32'h10, 32'h1F, 8'hA5, -1);
    push_res(0, 1'b1, 0, 1'b1);
    issue_start(32'h10, 32'h1F, 8'hA5);
    wait_done("basic", 300);
    noise = 1'b0;

    corrupt_addr = 32'h14;
    push_range(32'h10, 32'h1F, 8'hA5, -1);
    push_res(1, 1'b0, 32'h14, 1'b1);
    issue_start(32'h10, 32'h1F, 8'hA5);
    wait_done("corrupt", 300);
    corrupt_addr = -1;

    // Top of the address space: 0xFF^0xFF^0x01^0x3C = 0x3D, no wrap afterwards.
    begin
      req_t r;
      r.wr = 1'b1; r.addr = 32'h1FFFF; r.wdata = 8'h3D; r.gap = 0; req_q.push_back(r);
      r.wr = 1'b0; r.addr = 32'h1FFFF; r.wdata = 8'h00; r.gap = 1; req_q.push_back(r);
    end
    push_res(0, 1'b1, 0, 1'b1);
    issue_start(32'h1FFFF, 32'h1FFFF, 8'h3C);
    wait_done("top_addr", 100);

    push_res(1, 1'b0, 0, 1'b0);
    issue_start(32'h20, 32'h1F, 8'hA5);
    wait_done("bad_range", 50);

    drop_addr = 32'h12;
    push_range(32'h10, 32'h13, 8'hC3, 32'h12);
    push_res(1, 1'b0, 32'h12, 1'b1);
    issue_start(32'h10, 32'h13, 8'hC3);
    wait_done("timeout", 300);
    drop_addr = -1;

    // Data on the last wait cycle is compared, not timed out.
    slow_addr = 32'h12;
    push_range(32'h10, 32'h13, 8'h77, 32'h12);
    push_res(0, 1'b1, 0, 1'b1);
    issue_start(32'h10, 32'h13, 8'h77);
    wait_done("late_data", 300);
    slow_addr = -1;

    // Abort mid-write by reset, then a start during busy must be ignored.
    sb_on = 1'b0;
    issue_start(32'h100, 32'h1FF, 8'h11);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_on = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    repeat (4) @(negedge clk);
    push_range(32'h40, 32'h4F, 8'h5A, -1);
    push_res(0, 1'b1, 0, 1'b1);
    issue_start(32'h40, 32'h4F, 8'h5A);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_before_restart", busy, 1);
    base_addr = '0; last_addr = 17'h3; seed = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignored_start", 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bist_master.md
MEM_BIST_MASTER -- requirements
Module: mem_bist_master

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk input, rst_n input.
REQ-002 Parameter ADDR_W SHALL default to 17 and set the address width.
REQ-003 Parameter DATA_W SHALL default to 8 and set the data width.
REQ-004 Parameter TIMEOUT SHALL default to 16 and set the maximum cycles to wait for read data.
REQ-005 Port start SHALL be an input, 1 bit: a one-cycle pulse that launches a test.
REQ-006 Port base_addr SHALL be an input, ADDR_W bits: the first address tested.
REQ-007 Port last_addr SHALL be an input, ADDR_W bits: the final address tested, inclusive.
REQ-008 Port seed SHALL be an input, DATA_W bits: the pattern seed.
REQ-009 Port en SHALL be an output, 1 bit: the request strobe to the BRAM interface controller.
REQ-010 Port wr SHALL be an output, 1 bit: 1 for a write request, 0 for a read request.
REQ-011 Port addr_out SHALL be an output, ADDR_W bits: the request address.
REQ-012 Port wdata_out SHALL be an output, DATA_W bits: the write data.
REQ-013 Port rdata_in SHALL be an input, DATA_W bits: the read data from the controller.
REQ-014 Port rdata_rdy SHALL be an input, 1 bit: rdata_in is valid this cycle.
REQ-015 Port busy SHALL be an output, 1 bit: a test is in progress.
REQ-016 Port done SHALL be an output, 1 bit: a test has finished; it stays high until the next accepted start.
REQ-017 Port pass SHALL be an output, 1 bit: the finished test had zero errors; valid while done=1.
REQ-018 Port err_cnt SHALL be an output, 16 bits: the mismatch plus timeout count.
REQ-019 Port first_err_addr SHALL be an output, ADDR_W bits: the address of the first error.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, WRITE, RD_REQ, RD_WAIT and FIN.
REQ-021 The pattern SHALL be pat(a) = a[7:0] ^ a[15:8] ^ {7'b0,a[16]} ^ seed.
REQ-022 In IDLE or FIN, start SHALL capture base_addr, last_addr and seed, clear err_cnt, first_err_addr, done and pass, and move to WRITE on the next cycle.
REQ-023 If captured base > last, the FSM SHALL go directly to FIN with pass=0 and err_cnt=1, and SHALL issue no requests.
REQ-024 In WRITE, each cycle SHALL drive en=1, wr=1, addr_out=a and wdata_out=pat(a), then increment a; one write SHALL be issued per cycle, back to back.
REQ-025 After the write to last, the FSM SHALL reset a to base and enter RD_REQ.
REQ-026 In RD_REQ, the block SHALL drive en=1, wr=0 and addr_out=a for exactly one cycle, then enter RD_WAIT with a zeroed timeout counter.
REQ-027 At most one read SHALL be outstanding at any time.
REQ-028 In RD_WAIT, when rdata_rdy=1, the block SHALL compare rdata_in with pat(a); a mismatch is one error.
REQ-029 In RD_WAIT, if TIMEOUT cycles elapse without rdata_rdy, that is one error.
REQ-030 If rdata_rdy=1 arrives in the same cycle as the timeout, the data SHALL be compared and no timeout error SHALL be counted.
REQ-031 After each read (data or timeout), the FSM SHALL enter FIN if a == last; otherwise it SHALL increment a and return to RD_REQ.
REQ-032 Address iteration SHALL end at last and never wrap; last = 2^ADDR_W-1 SHALL terminate correctly without overflow.
REQ-033 When base == last, the block SHALL perform exactly one write and one read.
REQ-034 err_cnt SHALL saturate at 16'hFFFF.
REQ-035 first_err_addr SHALL be written only on the error that takes err_cnt from 0 to 1.
REQ-036 In FIN, the block SHALL set done=1, busy=0 and pass=(err_cnt==0).
REQ-037 busy SHALL be 1 in WRITE, RD_REQ and RD_WAIT.
REQ-038 start while busy=1 SHALL be ignored.
REQ-039 rdata_rdy outside RD_WAIT SHALL be ignored.
REQ-040 en SHALL be 0 in IDLE, RD_WAIT and FIN.

Reset
REQ-041 On rst_n=0 at a clk edge, the FSM SHALL enter IDLE.
REQ-042 On that reset, en, wr, addr_out, wdata_out, busy, done, pass, err_cnt and first_err_addr SHALL all be 0.
REQ-043 Reset mid-test SHALL abort immediately with no further requests and leave done=0.

Structure
REQ-044 Package mem_ctrl_pkg SHALL hold ADDR_W/DATA_W defaults, the state enum typedef and the pat() function.
REQ-045 The block SHALL be a single module with no sub-module; the pattern SHALL come from the package function.

Verification
REQ-046 base=0x00010, last=0x0001F, seed=0xA5, correct memory -> 16 back-to-back writes, 16 reads, done=1, pass=1, err_cnt=0.
REQ-047 Same range, with the memory model corrupting address 0x00014 -> err_cnt=1, first_err_addr=0x00014, pass=0.
REQ-048 base=last=0x1FFFF -> exactly one write and one read, then FIN with no wrap to 0x00000.
REQ-049 base=0x00020, last=0x0001F -> no en pulses, done=1, pass=0, err_cnt=1.
REQ-050 rdata_rdy held low on the read of 0x00012 -> a timeout after 16 cycles, err_cnt=1, and the test continues to 0x00013.
REQ-051 rst_n low for 1 cycle in mid-WRITE, followed by a start pulse during busy -> outputs return to reset values, and the start during busy is ignored.
